// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage.
package wb_stage_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  // Load funct3 encodings (instr[14:12]).
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_HELD  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data formatter: selects the byte/half/word at the byte offset
// inside an aligned doubleword and sign- or zero-extends it.
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_off,
  input  logic [XLEN-1:0] i_raw,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;

  // Misaligned half/word offsets simply take the low bits of the shifted value.
  assign w_shift = i_raw >> {i_off, 3'b000};

  // Extend the selected field according to funct3.
  always_comb begin
    o_data = w_shift;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_shift[7]}},   w_shift[7:0]};
      F3_LH:   o_data = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      F3_LW:   o_data = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
      F3_LD:   o_data = i_raw;
      F3_LBU:  o_data = {{(XLEN-8){1'b0}},  w_shift[7:0]};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      F3_LWU:  o_data = {{(XLEN-32){1'b0}}, w_shift[31:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges MEM-stage retirements and div/mul results onto the
// single regfile write port and emits the in-order commit stream.
//
// state    | meaning
// WB_EMPTY | skid empty; both MEM and div ports may be accepted
// WB_HELD  | skid holds a MEM entry displaced by an older div result;
//          | both inputs blocked while it drains
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem_i,
  input  logic [XLEN-1:0] pc_mem_i,
  input  logic [ILEN-1:0] instr_mem_i,
  input  logic [4:0]      rdid_mem_i,
  input  logic            wben_mem_i,
  input  logic            is_load_mem_i,
  input  logic [XLEN-1:0] alu_res_mem_i,
  input  logic [XLEN-1:0] ldata_mem_i,
  output logic            stalln_mem_o,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic [4:0]      div_rdid_i,
  input  logic [XLEN-1:0] div_data_i,
  input  logic [XLEN-1:0] div_pc_i,
  input  logic [ILEN-1:0] div_instr_i,
  output logic            wb_wren_o,
  output logic [4:0]      wb_rdid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            commit_o,
  output logic [XLEN-1:0] pc_wb_o,
  output logic [ILEN-1:0] instr_wb_o
);

  logic [XLEN-1:0] w_ldata_fmt;
  logic [XLEN-1:0] w_mem_data;
  logic            w_mem_acc;
  logic            w_div_acc;

  wb_state_e       r_state;
  logic            r_skid_vld;
  logic [4:0]      r_skid_rdid;
  logic            r_skid_wben;
  logic [XLEN-1:0] r_skid_data;
  logic [XLEN-1:0] r_skid_pc;
  logic [ILEN-1:0] r_skid_instr;

  wb_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .i_funct3 (instr_mem_i[14:12]),
    .i_off    (alu_res_mem_i[2:0]),
    .i_raw    (ldata_mem_i),
    .o_data   (w_ldata_fmt)
  );

  assign w_mem_data = is_load_mem_i ? w_ldata_fmt : alu_res_mem_i;
  assign w_mem_acc  = valid_mem_i & stalln_mem_o;
  assign w_div_acc  = div_valid_i & div_ready_o;

  // Arbitration FSM with registered outputs; div wins a collision because it is older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WB_EMPTY;
      r_skid_vld   <= 1'b0;
      r_skid_rdid  <= '0;
      r_skid_wben  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      stalln_mem_o <= 1'b1;
      div_ready_o  <= 1'b1;
      wb_wren_o    <= 1'b0;
      wb_rdid_o    <= '0;
      wb_data_o    <= '0;
      commit_o     <= 1'b0;
      pc_wb_o      <= '0;
      instr_wb_o   <= '0;
    end else begin
      case (r_state)
        WB_EMPTY: begin
          if (w_div_acc) begin
            wb_wren_o  <= (div_rdid_i != 5'd0);
            wb_rdid_o  <= div_rdid_i;
            wb_data_o  <= div_data_i;
            commit_o   <= 1'b1;
            pc_wb_o    <= div_pc_i;
            instr_wb_o <= div_instr_i;
            if (w_mem_acc) begin
              r_skid_vld   <= 1'b1;
              r_skid_rdid  <= rdid_mem_i;
              r_skid_wben  <= wben_mem_i;
              r_skid_data  <= w_mem_data;
              r_skid_pc    <= pc_mem_i;
              r_skid_instr <= instr_mem_i;
              stalln_mem_o <= 1'b0;
              div_ready_o  <= 1'b0;
              r_state      <= WB_HELD;
            end
          end else if (w_mem_acc) begin
            wb_wren_o  <= wben_mem_i & (rdid_mem_i != 5'd0);
            wb_rdid_o  <= rdid_mem_i;
            wb_data_o  <= w_mem_data;
            commit_o   <= 1'b1;
            pc_wb_o    <= pc_mem_i;
            instr_wb_o <= instr_mem_i;
          end else begin
            wb_wren_o <= 1'b0;
            commit_o  <= 1'b0;
          end
        end
        WB_HELD: begin
          wb_wren_o    <= r_skid_vld & r_skid_wben & (r_skid_rdid != 5'd0);
          wb_rdid_o    <= r_skid_rdid;
          wb_data_o    <= r_skid_data;
          commit_o     <= r_skid_vld;
          pc_wb_o      <= r_skid_pc;
          instr_wb_o   <= r_skid_instr;
          r_skid_vld   <= 1'b0;
          stalln_mem_o <= 1'b1;
          div_ready_o  <= 1'b1;
          r_state      <= WB_EMPTY;
        end
        default: begin
          r_state      <= WB_EMPTY;
          stalln_mem_o <= 1'b1;
          div_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule
